board_keeper: RTL and testbench

BOARD_KEEPER -- requirements
Module: board_keeper

---
 rtl/board_keeper.sv | 233 +++++++++++++++++++++++
 tb/tb_board_keeper.sv | 299 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/board_keeper.sv
// Connect-four board keeper: validates human/AI moves, places pieces, and
// scans the four line directions through each placed piece for a win or draw.
module board_keeper (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        new_game,
  input  logic [2:0]  hum_col,
  input  logic        hum_valid,
  input  logic [6:0]  ai_opt,
  input  logic        ai_move,
  output logic [83:0] grid,
  output logic [20:0] column_counts,
  output logic        player,
  output logic        busy,
  output logic        reject,
  output logic [1:0]  winner,
  output logic        game_over
);

  typedef enum logic [0:0] {IDLE = 1'b0, CHECK = 1'b1} state_t;

  state_t      state_r;
  logic [1:0]  dir_r;
  logic [83:0] grid_r;
  logic [20:0] counts_r;
  logic        player_r;
  logic        busy_r;
  logic        reject_r;
  logic [1:0]  winner_r;
  logic        game_over_r;
  logic        win_r;
  logic [2:0]  pc_r;
  logic [2:0]  pr_r;
  logic [1:0]  color_r;

  logic [2:0]        hum_col_safe_s;
  logic [2:0]        hum_cnt_s;
  logic              hum_legal_s;
  logic [3:0]        ai_mod_s;
  logic [6:0]        ai_row_s;
  logic [2:0]        ai_col_s;
  logic [2:0]        ai_cnt_s;
  logic              ai_legal_s;
  logic              mv_req_s;
  logic              mv_legal_s;
  logic [2:0]        mv_col_s;
  logic [2:0]        mv_row_s;
  logic [1:0]        mv_color_s;
  logic [6:0]        mv_gidx_s;
  logic [4:0]        mv_cidx_s;
  logic signed [4:0] step_c_s;
  logic signed [4:0] step_r_s;
  logic [2:0]        line_len_s;
  logic              line_win_s;
  logic              full_s;

  // MSB position of cell (c, r) in the packed grid.
  function automatic logic [6:0] gidx(input logic [2:0] c, input logic [2:0] r);
    return 7'd13 - {3'b000, c, 1'b0} + 7'd14 * {4'b0000, r};
  endfunction

  function automatic logic [1:0] cell_at(input logic [83:0] g, input logic [2:0] c,
                                         input logic [2:0] r);
    return g[gidx(c, r) -: 2];
  endfunction

  function automatic logic [2:0] count_of(input logic [20:0] cnt, input logic [2:0] c);
    return cnt[5'd3 * {2'b00, c} +: 3];
  endfunction

  // Contiguous same-colour cells beyond (c0, r0) in one sense, at most 3.
  function automatic logic [2:0] run_len(input logic [83:0] g, input logic [2:0] c0,
                                         input logic [2:0] r0, input logic [1:0] color,
                                         input logic signed [4:0] dc,
                                         input logic signed [4:0] dr);
    logic [2:0]        n;
    logic              run;
    logic signed [4:0] c;
    logic signed [4:0] r;
    n   = 3'd0;
    run = 1'b1;
    c   = $signed({2'b00, c0});
    r   = $signed({2'b00, r0});
    for (int k = 0; k < 3; k++) begin
      c = c + dc;
      r = r + dr;
      if (run && (c >= 5'sd0) && (c <= 5'sd6) && (r >= 5'sd0) && (r <= 5'sd5) &&
          (cell_at(g, c[2:0], r[2:0]) == color)) begin
        n = n + 3'd1;
      end else begin
        run = 1'b0;
      end
    end
    return n;
  endfunction

  // Legality of the two request sources against the current column heights.
  always_comb begin
    hum_col_safe_s = (hum_col <= 3'd6) ? hum_col : 3'd0;
    hum_cnt_s      = count_of(counts_r, hum_col_safe_s);
    hum_legal_s    = (hum_col <= 3'd6) && (hum_cnt_s < 3'd6);
    ai_mod_s       = 4'(ai_opt % 7'd14);
    ai_row_s       = ai_opt / 7'd14;
    ai_col_s       = 3'((4'd13 - ai_mod_s) >> 1);
    ai_cnt_s       = count_of(counts_r, ai_col_s);
    ai_legal_s     = ai_mod_s[0] && (ai_row_s < 7'd6) && (ai_row_s[2:0] == ai_cnt_s);
  end

  // Select the request of the side to move; the other side's strobe is ignored.
  always_comb begin
    mv_req_s   = 1'b0;
    mv_legal_s = 1'b0;
    mv_col_s   = 3'd0;
    mv_row_s   = 3'd0;
    mv_color_s = 2'b00;
    if ((state_r == IDLE) && !game_over_r) begin
      if (!player_r) begin
        mv_req_s   = hum_valid;
        mv_legal_s = hum_legal_s;
        mv_col_s   = hum_col_safe_s;
        mv_row_s   = hum_cnt_s;
        mv_color_s = 2'b01;
      end else begin
        mv_req_s   = ai_move;
        mv_legal_s = ai_legal_s;
        mv_col_s   = ai_col_s;
        mv_row_s   = ai_row_s[2:0];
        mv_color_s = 2'b10;
      end
    end else begin
      mv_req_s = 1'b0;
    end
    mv_gidx_s = gidx(mv_col_s, mv_row_s);
    mv_cidx_s = 5'd3 * {2'b00, mv_col_s};
  end

  // Line length through the placed cell along the current direction.
  always_comb begin
    case (dir_r)
      2'd0:    begin step_c_s = 5'sd1;  step_r_s = 5'sd0; end
      2'd1:    begin step_c_s = 5'sd0;  step_r_s = 5'sd1; end
      2'd2:    begin step_c_s = 5'sd1;  step_r_s = 5'sd1; end
      2'd3:    begin step_c_s = -5'sd1; step_r_s = 5'sd1; end
      default: begin step_c_s = 5'sd0;  step_r_s = 5'sd0; end
    endcase
    line_len_s = 3'd1 + run_len(grid_r, pc_r, pr_r, color_r, step_c_s, step_r_s)
                      + run_len(grid_r, pc_r, pr_r, color_r, -step_c_s, -step_r_s);
    line_win_s = (line_len_s >= 3'd4);
    full_s     = (counts_r == {7{3'd6}});
  end

  // Game state machine: accept/reject in IDLE, four direction scans in CHECK.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= IDLE;
      dir_r       <= 2'd0;
      grid_r      <= 84'd0;
      counts_r    <= 21'd0;
      player_r    <= 1'b0;
      busy_r      <= 1'b0;
      reject_r    <= 1'b0;
      winner_r    <= 2'b00;
      game_over_r <= 1'b0;
      win_r       <= 1'b0;
      pc_r        <= 3'd0;
      pr_r        <= 3'd0;
      color_r     <= 2'b00;
    end else if (new_game) begin
      state_r     <= IDLE;
      dir_r       <= 2'd0;
      grid_r      <= 84'd0;
      counts_r    <= 21'd0;
      player_r    <= 1'b0;
      busy_r      <= 1'b0;
      reject_r    <= 1'b0;
      winner_r    <= 2'b00;
      game_over_r <= 1'b0;
      win_r       <= 1'b0;
    end else begin
      reject_r <= 1'b0;
      case (state_r)
        IDLE: begin
          if (mv_req_s) begin
            if (mv_legal_s) begin
              grid_r[mv_gidx_s -: 2]   <= mv_color_s;
              counts_r[mv_cidx_s +: 3] <= mv_row_s + 3'd1;
              pc_r    <= mv_col_s;
              pr_r    <= mv_row_s;
              color_r <= mv_color_s;
              win_r   <= 1'b0;
              busy_r  <= 1'b1;
              dir_r   <= 2'd0;
              state_r <= CHECK;
            end else begin
              reject_r <= 1'b1;
            end
          end
        end
        CHECK: begin
          if (line_win_s) begin
            win_r <= 1'b1;
          end
          if (dir_r == 2'd3) begin
            state_r <= IDLE;
            busy_r  <= 1'b0;
            dir_r   <= 2'd0;
            if (win_r || line_win_s) begin
              winner_r    <= color_r;
              game_over_r <= 1'b1;
            end else if (full_s) begin
              winner_r    <= 2'b11;
              game_over_r <= 1'b1;
            end else begin
              player_r <= ~player_r;
            end
          end else begin
            dir_r <= dir_r + 2'd1;
          end
        end
        default: state_r <= IDLE;
      endcase
    end
  end

  assign grid          = grid_r;
  assign column_counts = counts_r;
  assign player        = player_r;
  assign busy          = busy_r;
  assign reject        = reject_r;
  assign winner        = winner_r;
  assign game_over     = game_over_r;

endmodule

// File: tb/tb_board_keeper.sv
// Bench for board_keeper: a board-level model (heights, cells, whole-board
// four-in-a-row scan) is compared every cycle, plus directed literal checks.
module tb_board_keeper;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        new_game;
  logic [2:0]  hum_col;
  logic        hum_valid;
  logic [6:0]  ai_opt;
  logic        ai_move;
  logic [83:0] grid;
  logic [20:0] column_counts;
  logic        player;
  logic        busy;
  logic        reject;
  logic [1:0]  winner;
  logic        game_over;

  board_keeper dut (
    .clk(clk), .rst_n(rst_n), .new_game(new_game), .hum_col(hum_col),
    .hum_valid(hum_valid), .ai_opt(ai_opt), .ai_move(ai_move), .grid(grid),
    .column_counts(column_counts), .player(player), .busy(busy), .reject(reject),
    .winner(winner), .game_over(game_over)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Model state: cells hold 0 empty, 1 human, 2 AI.
  int mb [0:5][0:6];
  int mh [0:6];
  int mplayer, mbusy, mreject, mwinner, mgo, mcnt;
  int pend_win, pend_full, pend_color;

  task automatic check(input string name, input logic [83:0] act, input logic [83:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int r = 0; r < 6; r++)
      for (int c = 0; c < 7; c++) mb[r][c] = 0;
    for (int c = 0; c < 7; c++) mh[c] = 0;
    mplayer = 0; mbusy = 0; mreject = 0; mwinner = 0; mgo = 0; mcnt = 0;
    pend_win = 0; pend_full = 0; pend_color = 0;
  endtask

  function automatic int four(input int col);
    int dc, dr, cc, rr, ok;
    for (int d = 0; d < 4; d++) begin
      case (d)
        0:       begin dc = 1; dr = 0;  end
        1:       begin dc = 0; dr = 1;  end
        2:       begin dc = 1; dr = 1;  end
        default: begin dc = 1; dr = -1; end
      endcase
      for (int r = 0; r < 6; r++)
        for (int c = 0; c < 7; c++) begin
          ok = 1;
          for (int k = 0; k < 4; k++) begin
            cc = c + k * dc;
            rr = r + k * dr;
            if (cc < 0 || cc > 6 || rr < 0 || rr > 5) ok = 0;
            else if (mb[rr][cc] != col) ok = 0;
          end
          if (ok != 0) return 1;
        end
    end
    return 0;
  endfunction

  task automatic model_place(input int c, input int col);
    int full;
    mb[mh[c]][c] = col;
    mh[c] = mh[c] + 1;
    full = 1;
    for (int i = 0; i < 7; i++) if (mh[i] != 6) full = 0;
    pend_win = four(col);
    pend_full = full;
    pend_color = col;
    mbusy = 1;
    mcnt = 4;
  endtask

  task automatic model_step();
    int m, row, c;
    if (!rst_n || new_game) begin
      model_reset();
    end else begin
      mreject = 0;
      if (mbusy != 0) begin
        mcnt--;
        if (mcnt == 0) begin
          mbusy = 0;
          if (pend_win != 0) begin mwinner = pend_color; mgo = 1; end
          else if (pend_full != 0) begin mwinner = 3; mgo = 1; end
          else mplayer = 1 - mplayer;
        end
      end else if (mgo == 0) begin
        if (mplayer == 0 && hum_valid) begin
          c = int'(hum_col);
          if (c <= 6 && mh[c] < 6) model_place(c, 1);
          else mreject = 1;
        end else if (mplayer == 1 && ai_move) begin
          m = int'(ai_opt) % 14;
          row = int'(ai_opt) / 14;
          c = (13 - m) / 2;
          if (m % 2 == 1 && row < 6 && row == mh[c]) model_place(c, 2);
          else mreject = 1;
        end
      end
    end
  endtask

  function automatic logic [83:0] exp_grid();
    logic [83:0] g;
    g = 84'd0;
    for (int r = 5; r >= 0; r--)
      for (int c = 0; c < 7; c++) g = {g[81:0], 2'(mb[r][c])};
    return g;
  endfunction

  function automatic logic [20:0] exp_counts();
    logic [20:0] v;
    v = 21'd0;
    for (int c = 6; c >= 0; c--) v = {v[17:0], 3'(mh[c])};
    return v;
  endfunction

  // Single compare process: advance the model on each edge, check just after.
  initial begin
    model_reset();
    forever begin
      @(posedge clk);
      model_step();
      #1;
      check("grid", grid, exp_grid());
      check("column_counts", 84'(column_counts), 84'(exp_counts()));
      check("player", 84'(player), 84'(mplayer));
      check("busy", 84'(busy), 84'(mbusy));
      check("reject", 84'(reject), 84'(mreject));
      check("winner", 84'(winner), 84'(mwinner));
      check("game_over", 84'(game_over), 84'(mgo));
    end
  end

  task automatic hum(input int col);
    hum_col = 3'(col); hum_valid = 1'b1;
    @(negedge clk);
    hum_valid = 1'b0;
  endtask

  task automatic ai(input int opt);
    ai_opt = 7'(opt); ai_move = 1'b1;
    @(negedge clk);
    ai_move = 1'b0;
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse_new_game();
    new_game = 1'b1;
    @(negedge clk);
    new_game = 1'b0;
  endtask

  int ht [0:6];
  int rc;

  initial begin
    rst_n = 1'b0; new_game = 1'b0; hum_col = 3'd0; hum_valid = 1'b0;
    ai_opt = 7'd0; ai_move = 1'b0;
    wait_cyc(2);
    rst_n = 1'b1;
    wait_cyc(1);

    // First human move and busy window.
    hum(3);
    check("lit_busy_after_accept", 84'(busy), 84'd1);
    check("lit_grid_h3", grid, 84'h40);
    check("lit_counts_h3", 84'(column_counts), 84'h200);
    wait_cyc(3);
    check("lit_player_before_toggle", 84'(player), 84'd0);
    wait_cyc(1);
    check("lit_player_after_h3", 84'(player), 84'd1);

    // Illegal (even) AI target then a legal one.
    ai(6);
    check("lit_reject_even", 84'(reject), 84'd1);
    check("lit_grid_after_reject", grid, 84'h40);
    wait_cyc(1);
    check("lit_reject_cleared", 84'(reject), 84'd0);
    ai(21);
    wait_cyc(4);
    check("lit_grid_ai21", grid, 84'h200040);
    check("lit_counts_ai21", 84'(column_counts), 84'h400);
    check("lit_player_after_ai", 84'(player), 84'd0);

    // Asynchronous reset in the middle of a check.
    hum(2);
    #2 rst_n = 1'b0;
    #1;
    check("lit_rst_grid", grid, 84'd0);
    check("lit_rst_counts", 84'(column_counts), 84'd0);
    check("lit_rst_busy", 84'(busy), 84'd0);
    check("lit_rst_player", 84'(player), 84'd0);
    check("lit_rst_winner", 84'(winner), 84'd0);
    @(negedge clk);
    rst_n = 1'b1;
    hum(3);
    wait_cyc(4);
    check("lit_counts_after_rst", 84'(column_counts), 84'h200);
    pulse_new_game();

    // Fill column 0, then an overflowing human request.
    hum(0); wait_cyc(4); ai(27); wait_cyc(4);
    hum(0); wait_cyc(4); ai(55); wait_cyc(4);
    hum(0); wait_cyc(4); ai(83); wait_cyc(4);
    hum(0);
    check("lit_reject_full_col", 84'(reject), 84'd1);
    check("lit_grid_full_col", grid, 84'h800100080010008001000);
    check("lit_counts_full_col", 84'(column_counts), 84'h6);
    check("lit_player_full_col", 84'(player), 84'd0);
    wait_cyc(1);
    pulse_new_game();

    // Horizontal human win on the bottom row.
    hum(0); wait_cyc(4); ai(1);  wait_cyc(4);
    hum(1); wait_cyc(4); ai(15); wait_cyc(4);
    hum(2); wait_cyc(4); ai(29); wait_cyc(4);
    hum(3); wait_cyc(4);
    check("lit_winner_human", 84'(winner), 84'h1);
    check("lit_game_over_win", 84'(game_over), 84'd1);
    check("lit_player_win", 84'(player), 84'd0);
    hum_col = 3'd4; hum_valid = 1'b1; ai_opt = 7'd43; ai_move = 1'b1;
    @(negedge clk);
    hum_valid = 1'b0; ai_move = 1'b0;
    check("lit_no_reject_after_over", 84'(reject), 84'd0);
    check("lit_counts_frozen", 84'(column_counts), 84'hC0249);
    wait_cyc(2);
    pulse_new_game();
    check("lit_cleared_grid", grid, 84'd0);
    check("lit_cleared_winner", 84'(winner), 84'd0);

    // Scripted draw: column pairs (0,2), (1,3), (4,6), then column 5.
    for (int c = 0; c < 7; c++) ht[c] = 0;
    for (int p = 0; p < 3; p++) begin
      int a, b;
      a = (p == 0) ? 0 : (p == 1) ? 1 : 4;
      b = a + 2;
      for (int i = 0; i < 3; i++) begin
        hum(a); ht[a]++; wait_cyc(4);
        ai(14 * ht[b] + 13 - 2 * b); ht[b]++; wait_cyc(4);
        hum(b); ht[b]++; wait_cyc(4);
        ai(14 * ht[a] + 13 - 2 * a); ht[a]++; wait_cyc(4);
      end
    end
    for (int i = 0; i < 3; i++) begin
      hum(5); ht[5]++; wait_cyc(4);
      ai(14 * ht[5] + 3); ht[5]++;
      if (i < 2) wait_cyc(4);
    end
    wait_cyc(3);
    check("lit_draw_pending", 84'(game_over), 84'd0);
    wait_cyc(1);
    check("lit_draw_winner", 84'(winner), 84'h3);
    check("lit_draw_over", 84'(game_over), 84'd1);
    pulse_new_game();

    // Random play against the model.
    for (int cyc = 0; cyc < 1500; cyc++) begin
      hum_valid = ($urandom_range(0, 2) == 0);
      hum_col   = 3'($urandom_range(0, 7));
      ai_move   = ($urandom_range(0, 2) == 0);
      if ($urandom_range(0, 1) == 0) begin
        rc = int'($urandom_range(0, 6));
        ai_opt = 7'(14 * mh[rc] + 13 - 2 * rc);
      end else begin
        ai_opt = 7'($urandom_range(0, 127));
      end
      new_game = ($urandom_range(0, 59) == 0);
      @(negedge clk);
    end
    hum_valid = 1'b0; ai_move = 1'b0; new_game = 1'b0;
    wait_cyc(6);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
